// File: rtl/eth_rx_filter_pkg.sv
// Shared types and constants for the Ethernet RX destination-address filter.
package eth_rx_filter_pkg;

  typedef enum logic [2:0] {IDLE, HDR, PASS, FLUSH, TRUNC, DROP} rx_state_e;

  localparam logic [47:0] ETH_ADDR_BCAST = 48'hFFFF_FFFF_FFFF;
  localparam int          ETH_HDR_DA_LEN = 6;
  // Widest tuser the delay line can carry; modules use the low USER_WIDTH bits.
  localparam int          ETH_USER_MAX   = 16;

  typedef struct packed {
    logic [7:0]              data;
    logic [ETH_USER_MAX-1:0] user;
  } dl_entry_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/eth_rx_delay_line.sv
// Six-deep {data,user} shift register holding the DA; oldest entry is popped
// one per pop during flush, tracked by a fill count.
module eth_rx_delay_line
  import eth_rx_filter_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clr,
  input  logic                              shift,
  input  logic                              pop,
  input  dl_entry_t                         din,
  output dl_entry_t                         head,
  output logic                              last,
  output logic                              empty,
  output logic [8*(ETH_HDR_DA_LEN-1)-1:0]   da_prefix
);

  localparam int DEPTH = ETH_HDR_DA_LEN;

  dl_entry_t [DEPTH-1:0] line;
  logic [2:0]            fill;
  logic [2:0]            rd_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      line <= '0;
      fill <= '0;
    end else begin
      if (shift) begin
        line[0] <= din;
        for (int i = 1; i < DEPTH; i++) line[i] <= line[i-1];
      end
      if (clr)
        fill <= shift ? 3'd1 : 3'd0;
      else if (shift && !pop)
        fill <= (fill == 3'(DEPTH)) ? fill : fill + 3'd1;
      else if (pop && !shift && fill != 3'd0)
        fill <= fill - 3'd1;
    end
  end

  // Oldest valid entry sits at index fill-1
  assign rd_idx = (fill == 3'd0) ? 3'd0 : fill - 3'd1;
  assign head   = line[rd_idx];
  assign last   = (fill == 3'd1);
  assign empty  = (fill == 3'd0);

  for (genvar g = 0; g < DEPTH-1; g++) begin : g_da
    assign da_prefix[8*g +: 8] = line[g].data;
  end

endmodule

// File: rtl/eth_rx_da_filter.sv
// RX destination-address filter with min/max length enforcement.
// Optional statistics counters enabled by `define ETH_RX_FILTER_STATS_EN.
module eth_rx_da_filter
  import eth_rx_filter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int MIN_LEN    = 60,
  parameter int MAX_LEN    = 1518
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  input  logic [47:0]           cfg_mac_addr,
  input  logic                  cfg_filter_enable,
  input  logic                  cfg_mcast_enable,
  output logic                  drop_filter,
  output logic                  error_runt,
  output logic                  error_oversize,
`ifdef ETH_RX_FILTER_STATS_EN
  input  logic                  stat_clear,
  output logic [31:0]           stat_rx_frames,
  output logic [31:0]           stat_rx_drop_filter,
  output logic [31:0]           stat_rx_runt,
  output logic [31:0]           stat_rx_oversize,
`endif
  output logic                  error_overrun
);

  if (DATA_WIDTH != 8) begin : g_bad_data_width
    $error("eth_rx_da_filter: DATA_WIDTH must be 8");
  end
  if (USER_WIDTH < 1 || USER_WIDTH > ETH_USER_MAX) begin : g_bad_user_width
    $error("eth_rx_da_filter: USER_WIDTH out of range");
  end

  rx_state_e state, state_n;
  logic [15:0] count, cnt_n, cnt_inc;
  logic        err_flag, err_n;
  logic        drop_after, drop_after_n;
  logic        short_frame;

  logic        dl_shift, dl_pop, dl_clr, dl_last, dl_empty;
  dl_entry_t   dl_din, dl_head;
  logic [39:0] dl_da_prefix;

  logic [47:0] da;
  logic        accept;
  logic        out_fire, out_last;
  logic [USER_WIDTH-1:0] out_user;
  logic        drop_p, runt_p, over_p, ovr_p;
  logic        unused_bits;

  eth_rx_delay_line u_dl (
    .clk       (clk),
    .rst       (rst),
    .clr       (dl_clr),
    .shift     (dl_shift),
    .pop       (dl_pop),
    .din       (dl_din),
    .head      (dl_head),
    .last      (dl_last),
    .empty     (dl_empty),
    .da_prefix (dl_da_prefix)
  );

  always_comb begin
    dl_din = '0;
    dl_din.data = s_axis_tdata;
    dl_din.user[USER_WIDTH-1:0] = s_axis_tuser;
  end

  assign unused_bits = ^{dl_head.user, dl_empty};

  // Byte 6 is still on the input when the decision is made
  assign da     = {dl_da_prefix, s_axis_tdata};
  assign accept = !cfg_filter_enable || (da == cfg_mac_addr) ||
                  (da == ETH_ADDR_BCAST) || (da[40] && cfg_mcast_enable);

  assign cnt_inc     = (count == 16'hFFFF) ? count : count + 16'd1;
  assign short_frame = (cnt_inc < 16'(MIN_LEN));

  always_comb begin
    state_n      = state;
    cnt_n        = count;
    err_n        = err_flag;
    drop_after_n = drop_after;
    dl_shift     = 1'b0;
    dl_pop       = 1'b0;
    dl_clr       = 1'b0;
    out_fire     = 1'b0;
    out_last     = 1'b0;
    drop_p       = 1'b0;
    runt_p       = 1'b0;
    over_p       = 1'b0;
    ovr_p        = 1'b0;
    case (state)
      IDLE: if (s_axis_tvalid) begin
        dl_clr   = 1'b1;
        dl_shift = 1'b1;
        cnt_n    = 16'd1;
        if (s_axis_tlast) runt_p = 1'b1;
        else              state_n = HDR;
      end
      HDR: if (s_axis_tvalid) begin
        dl_shift = 1'b1;
        cnt_n    = cnt_inc;
        if (count == 16'(ETH_HDR_DA_LEN-1)) begin
          if (accept) begin
            if (s_axis_tlast) begin
              state_n      = FLUSH;
              err_n        = short_frame;
              runt_p       = short_frame;
              drop_after_n = 1'b0;
            end else begin
              state_n = PASS;
            end
          end else begin
            drop_p  = 1'b1;
            state_n = s_axis_tlast ? IDLE : DROP;
          end
        end else if (s_axis_tlast) begin
          runt_p  = 1'b1;
          state_n = IDLE;
        end
      end
      PASS: if (s_axis_tvalid) begin
        if (count >= 16'(MAX_LEN)) begin
          // Byte MAX_LEN+1 never enters the line
          over_p       = 1'b1;
          err_n        = 1'b1;
          drop_after_n = !s_axis_tlast;
          state_n      = TRUNC;
        end else begin
          dl_shift = 1'b1;
          out_fire = 1'b1;
          cnt_n    = cnt_inc;
          if (s_axis_tlast) begin
            state_n      = FLUSH;
            err_n        = short_frame;
            runt_p       = short_frame;
            drop_after_n = 1'b0;
          end
        end
      end
      FLUSH, TRUNC: begin
        dl_pop   = 1'b1;
        out_fire = 1'b1;
        // drop_after set: rest of the current input frame is still arriving
        if (s_axis_tvalid) begin
          if (drop_after) begin
            if (s_axis_tlast) drop_after_n = 1'b0;
          end else begin
            ovr_p        = 1'b1;
            drop_after_n = !s_axis_tlast;
          end
        end
        if (dl_last) begin
          out_last = 1'b1;
          state_n  = drop_after_n ? DROP : IDLE;
        end
      end
      DROP: if (s_axis_tvalid && s_axis_tlast) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    out_user = dl_head.user[USER_WIDTH-1:0];
    if (out_last) out_user[0] = dl_head.user[0] | err_flag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      count          <= '0;
      err_flag       <= 1'b0;
      drop_after     <= 1'b0;
      m_axis_tdata   <= '0;
      m_axis_tvalid  <= 1'b0;
      m_axis_tlast   <= 1'b0;
      m_axis_tuser   <= '0;
      drop_filter    <= 1'b0;
      error_runt     <= 1'b0;
      error_oversize <= 1'b0;
      error_overrun  <= 1'b0;
    end else begin
      state          <= state_n;
      count          <= cnt_n;
      err_flag       <= err_n;
      drop_after     <= drop_after_n;
      m_axis_tdata   <= out_fire ? dl_head.data : '0;
      m_axis_tvalid  <= out_fire;
      m_axis_tlast   <= out_fire & out_last;
      m_axis_tuser   <= out_fire ? out_user : '0;
      drop_filter    <= drop_p;
      error_runt     <= runt_p;
      error_oversize <= over_p;
      error_overrun  <= ovr_p;
    end
  end

`ifdef ETH_RX_FILTER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || stat_clear) begin
      stat_rx_frames      <= '0;
      stat_rx_drop_filter <= '0;
      stat_rx_runt        <= '0;
      stat_rx_oversize    <= '0;
    end else begin
      if (out_fire && out_last) stat_rx_frames <= sat_inc32(stat_rx_frames);
      if (drop_p) stat_rx_drop_filter <= sat_inc32(stat_rx_drop_filter);
      if (runt_p) stat_rx_runt        <= sat_inc32(stat_rx_runt);
      if (over_p) stat_rx_oversize    <= sat_inc32(stat_rx_oversize);
    end
  end
`endif

endmodule
